// File: rtl/sayeh_pkg.sv
// Shared op codes, FSM states and default datapath sizes for the SAYEH sequential ALU.
package sayeh_pkg;

  localparam int SAYEH_WIDTH = 16;
  localparam int SAYEH_MUL_W = 8;

  localparam logic [3:0] OP_PASSB = 4'd0;
  localparam logic [3:0] OP_AND   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_NOT   = 4'd3;
  localparam logic [3:0] OP_SHL   = 4'd4;
  localparam logic [3:0] OP_SHR   = 4'd5;
  localparam logic [3:0] OP_ADD   = 4'd6;
  localparam logic [3:0] OP_SUB   = 4'd7;
  localparam logic [3:0] OP_CMP   = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/sayeh_shift_add_mul.sv
// Iterative shift-add multiplier: load latches operands, each step retires one multiplier bit.
// o_product is the accumulator value after the current step, so the final step's sum is visible combinationally.
module sayeh_shift_add_mul #(
  parameter int MUL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [MUL_W-1:0]   i_a,
  input  logic [MUL_W-1:0]   i_b,
  output logic [2*MUL_W-1:0] o_product,
  output logic               o_last
);

  localparam int CW = (MUL_W > 1) ? $clog2(MUL_W) : 1;

  logic [2*MUL_W-1:0] r_mcand;
  logic [2*MUL_W-1:0] r_acc;
  logic [2*MUL_W-1:0] w_addend;
  logic [MUL_W-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;

  assign w_addend  = r_mplier[0] ? r_mcand : '0;
  assign o_product = r_acc + w_addend;
  assign o_last    = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_mcand  <= (2*MUL_W)'(i_a);
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= CW'(MUL_W - 1);
    end else if (i_step) begin
      r_acc    <= o_product;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (!o_last) r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/sayeh_seq_alu.sv
// SAYEH ALU: single-cycle ops finish one cycle after accept, MUL after MUL_W further cycles with busy high.
// Flags and sr_load are registered on posedge so the negedge-clocked status register sees stable values.
module sayeh_seq_alu
  import sayeh_pkg::*;
#(
  parameter int WIDTH = SAYEH_WIDTH,
  parameter int MUL_W = SAYEH_MUL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             z_out,
  output logic             sr_load
);

  alu_state_t         r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_sr_load;
  logic [WIDTH-1:0]   r_result;
  logic               r_c;
  logic               r_z;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_c;
  logic               w_alu_z;
  logic               w_legal;
  logic               w_accept;
  logic               w_mul_load;
  logic               w_mul_step;
  logic               w_mul_last;
  logic [2*MUL_W-1:0] w_mul_prod;

  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_mul_load = w_accept && (op == OP_MUL);
  assign w_mul_step = (r_state == ST_MUL);
  assign w_legal    = (op <= OP_MUL);

  sayeh_shift_add_mul #(.MUL_W(MUL_W)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_mul_load),
    .i_step    (w_mul_step),
    .i_a       (a[MUL_W-1:0]),
    .i_b       (b[MUL_W-1:0]),
    .o_product (w_mul_prod),
    .o_last    (w_mul_last)
  );

  // Logic ops pass cin through so the status register keeps its carry on reload.
  always_comb begin
    w_sum     = '0;
    w_alu_res = r_result;
    w_alu_c   = cin;
    case (op)
      OP_PASSB: w_alu_res = b;
      OP_AND:   w_alu_res = a & b;
      OP_OR:    w_alu_res = a | b;
      OP_NOT:   w_alu_res = ~a;
      OP_SHL: begin
        w_alu_res = a << 1;
        w_alu_c   = a[WIDTH-1];
      end
      OP_SHR: begin
        w_alu_res = a >> 1;
        w_alu_c   = a[0];
      end
      OP_ADD: begin
        w_sum     = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_sum     = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
      end
      OP_CMP:   w_alu_c = (a < b);
      default:  w_alu_res = r_result;
    endcase
    w_alu_z = (op == OP_CMP) ? (a == b) : (w_alu_res == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sr_load <= 1'b0;
      r_result  <= '0;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_sr_load <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (op == OP_MUL) begin
              r_state <= ST_MUL;
              r_busy  <= 1'b1;
            end else begin
              r_done <= 1'b1;
              if (w_legal) begin
                r_sr_load <= 1'b1;
                r_result  <= w_alu_res;
                r_c       <= w_alu_c;
                r_z       <= w_alu_z;
              end
            end
          end
        end
        ST_MUL: begin
          if (w_mul_last) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_sr_load <= 1'b1;
            r_result  <= WIDTH'(w_mul_prod);
            r_c       <= 1'b0;
            r_z       <= (w_mul_prod == '0);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign sr_load = r_sr_load;
  assign result  = r_result;
  assign c_out   = r_c;
  assign z_out   = r_z;

endmodule

// File: tb/tb_sayeh_seq_alu.sv
// Scoreboarded bench for sayeh_seq_alu: directed scenarios followed by random op streams.
module tb_sayeh_seq_alu;
  import sayeh_pkg::*;

  localparam int W = 16;
  localparam int M = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, c_out, z_out, sr_load;
  logic [W-1:0] result;

  always #5 clk = ~clk;

  sayeh_seq_alu #(.WIDTH(W), .MUL_W(M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .c_out(c_out), .z_out(z_out), .sr_load(sr_load)
  );

  typedef struct {
    int           cyc;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         srl;
  } exp_t;

  exp_t         sbq[$];
  exp_t         mon_e;
  int           vectors = 0;
  int           miscompares = 0;
  int           nidx = 0;
  logic [W-1:0] m_res = '0;
  logic         m_c = 1'b0;
  logic         m_z = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural result/flags.
  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, output exp_t e);
    longint lim;
    longint s;
    lim   = longint'(1) << W;
    e.cyc = 0;
    e.srl = 1'b1;
    e.res = m_res;
    e.c   = ci;
    e.z   = m_z;
    case (o)
      OP_PASSB: e.res = y;
      OP_AND:   e.res = x & y;
      OP_OR:    e.res = x | y;
      OP_NOT:   e.res = W'(lim - 1 - longint'(x));
      OP_SHL: begin
        s = longint'(x) * 2;
        e.res = W'(s % lim);
        e.c = (s >= lim);
      end
      OP_SHR: begin
        e.res = W'(longint'(x) / 2);
        e.c = (longint'(x) % 2) == 1;
      end
      OP_ADD: begin
        s = longint'(x) + longint'(y) + longint'(ci);
        e.res = W'(s % lim);
        e.c = (s >= lim);
      end
      OP_SUB: begin
        s = longint'(x) - longint'(y) - longint'(ci);
        e.res = W'((s + lim) % lim);
        e.c = (s < 0);
      end
      OP_CMP: begin
        e.c = (longint'(x) < longint'(y));
        e.z = (x == y);
      end
      OP_MUL: begin
        s = (longint'(x) % (longint'(1) << M)) * (longint'(y) % (longint'(1) << M));
        e.res = W'(s);
        e.c = 1'b0;
      end
      default: begin
        e.srl = 1'b0;
        e.c   = m_c;
      end
    endcase
    if (e.srl && o != OP_CMP) e.z = (e.res == '0);
    if (e.srl) begin
      m_res = e.res;
      m_c   = e.c;
      m_z   = e.z;
    end
  endtask

  // Waits for an idle DUT, presents the op, and queues its expected response at the accept edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int   guard;
    exp_t e;
    guard = 0;
    while (busy && guard < 100) begin
      start = 1'b0;
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles", busy, guard);
    end
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    cin = ci;
    @(posedge clk);
    model(o, x, y, ci, e);
    e.cyc = nidx + 1 + ((o == OP_MUL) ? M : 0);
    sbq.push_back(e);
    #1;
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    nidx++;
    if (rst_n) begin
      if (sr_load && !done) begin
        vectors++;
        miscompares++;
        $display("FAIL sr_load_without_done: sr_load=%b done=%b at cycle %0d", sr_load, done, nidx);
      end
      if (done) begin
        vectors++;
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: done=1 at cycle %0d with nothing outstanding", nidx);
        end else begin
          mon_e = sbq.pop_front();
          if (mon_e.cyc != nidx || result !== mon_e.res || c_out !== mon_e.c ||
              z_out !== mon_e.z || sr_load !== mon_e.srl) begin
            miscompares++;
            $display("FAIL done_response: got cyc=%0d res=%h c=%b z=%b srl=%b, expected cyc=%0d res=%h c=%b z=%b srl=%b",
                     nidx, result, c_out, z_out, sr_load, mon_e.cyc, mon_e.res, mon_e.c, mon_e.z, mon_e.srl);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] ro;
    int         guard;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {26'd0, busy, done, sr_load, c_out, z_out, 1'b0}, 32'd0);
    check("reset_result", {16'd0, result}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
    check("add_wrap_done", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    check("add_wrap_done_one_cycle", {31'd0, done}, 32'd0);

    issue(OP_ADD, 16'd5, 16'd3, 1'b1);
    issue(OP_SUB, 16'd3, 16'd5, 1'b0);
    issue(OP_CMP, 16'd7, 16'd7, 1'b0);
    @(posedge clk);
    #1;
    check("cmp_result_kept", {16'd0, result}, 32'h0000FFFE);

    issue(OP_MUL, 16'h00FF, 16'h00FF, 1'b0);
    for (int i = 0; i < M; i++) begin
      check("mul_busy", {31'd0, busy}, 32'd1);
      start = 1'b1;
      op = OP_ADD;
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("mul_busy_clear", {31'd0, busy}, 32'd0);
    check("mul_done", {31'd0, done}, 32'd1);
    check("mul_result", {16'd0, result}, 32'h0000FE01);

    issue(OP_NOT, 16'hFFFF, 16'h0000, 1'b1);
    issue(OP_SHR, 16'h0001, 16'h0000, 1'b0);
    @(posedge clk);
    #1;

    issue(4'hF, 16'h1234, 16'h5678, 1'b1);
    @(posedge clk);
    #1;

    issue(OP_MUL, 16'd12, 16'd10, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(sbq.pop_back());
    m_res = '0;
    m_c = 1'b0;
    m_z = 1'b0;
    #1;
    check("abort_outputs", {26'd0, busy, done, sr_load, c_out, z_out, 1'b0}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(OP_MUL, 16'd12, 16'd10, 1'b0);
    repeat (M + 1) @(posedge clk);
    #1;
    check("mul_after_abort", {16'd0, result}, 32'd120);

    for (int n = 0; n < 300; n++) begin
      ro = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      issue(ro, 16'($urandom), ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    guard = 0;
    while (sbq.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sbq.size());
    end
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
